// File: rtl/tape_player.sv
// ============================================================================
//  tape_player : biphase cassette playback generator (leader, sync, payload)
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tape_player #(
  parameter int         HALF_TICKS     = 742,
  parameter int         PREAMBLE_BYTES = 256,
  parameter logic [7:0] SYNC_BYTE      = 8'hE6
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_tick,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        tape_out,
  output logic        busy,
  output logic [15:0] byte_cnt
);

  localparam int c_TIMER_W = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
  localparam int c_PRE_W   = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(HALF_TICKS - 1);
  localparam logic [c_PRE_W-1:0]   c_PRE_LOAD   = c_PRE_W'(PREAMBLE_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_DATA     = 3'd3,
    ST_STALL    = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_TIMER_W-1:0] r_timer;
  logic [3:0]           r_half;
  logic [7:0]           r_shift;
  logic [c_PRE_W-1:0]   r_pre;
  logic [7:0]           r_hold;
  logic                 r_hold_valid;
  logic                 r_hold_last;
  logic                 r_last_seen;
  logic                 r_last_loaded;
  logic                 r_tape;
  logic                 r_busy;
  logic [15:0]          r_byte_cnt;

  logic                 w_accept;
  logic [15:0]          w_cnt_inc;

  assign s_ready   = r_busy & ~r_hold_valid & ~r_last_seen;
  assign w_accept  = s_valid & s_ready;
  assign w_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;

  assign tape_out  = r_tape;
  assign busy      = r_busy;
  assign byte_cnt  = r_byte_cnt;

  // r_shift[7] is always the bit on air; it shifts left as each bit completes,
  // so an underrun leaves it empty and the line parks on the first half of a 0.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_half        <= 4'd0;
      r_shift       <= 8'h00;
      r_pre         <= '0;
      r_hold        <= 8'h00;
      r_hold_valid  <= 1'b0;
      r_hold_last   <= 1'b0;
      r_last_seen   <= 1'b0;
      r_last_loaded <= 1'b0;
      r_tape        <= 1'b0;
      r_busy        <= 1'b0;
      r_byte_cnt    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_hold       <= s_data;
        r_hold_valid <= 1'b1;
        r_hold_last  <= s_last;
        if (s_last) r_last_seen <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_hold_valid  <= 1'b0;
            r_last_seen   <= 1'b0;
            r_last_loaded <= 1'b0;
            r_byte_cnt    <= 16'd0;
            r_shift       <= 8'h00;
            r_half        <= 4'd0;
            r_timer       <= '0;
            r_pre         <= c_PRE_LOAD;
            r_tape        <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_PREAMBLE;
          end
        end
        default: begin
          if (stop) begin
            r_state      <= ST_IDLE;
            r_tape       <= 1'b0;
            r_busy       <= 1'b0;
            r_hold_valid <= 1'b0;
            r_timer      <= '0;
          end else if (r_state == ST_STALL) begin
            if (r_hold_valid) begin
              r_shift       <= r_hold;
              r_hold_valid  <= 1'b0;
              r_last_loaded <= r_hold_last;
              r_byte_cnt    <= w_cnt_inc;
              r_tape        <= ~r_hold[7];
              r_half        <= 4'd0;
              r_timer       <= '0;
              r_state       <= ST_DATA;
            end
          end else if (ce_tick) begin
            if (r_timer != c_TIMER_LAST) begin
              r_timer <= r_timer + 1'b1;
            end else begin
              r_timer <= '0;
              if (r_half != 4'd15) begin
                r_half <= r_half + 4'd1;
                if (!r_half[0]) begin
                  r_tape <= r_shift[7];
                end else begin
                  r_tape  <= ~r_shift[6];
                  r_shift <= {r_shift[6:0], 1'b0};
                end
              end else begin
                r_half <= 4'd0;
                if (r_state == ST_PREAMBLE) begin
                  if (r_pre != '0) begin
                    r_pre   <= r_pre - 1'b1;
                    r_shift <= 8'h00;
                    r_tape  <= 1'b1;
                  end else begin
                    r_shift <= SYNC_BYTE;
                    r_tape  <= ~SYNC_BYTE[7];
                    r_state <= ST_SYNC;
                  end
                end else if (r_state == ST_DATA && r_last_loaded) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_tape  <= 1'b0;
                end else if (r_hold_valid) begin
                  r_shift       <= r_hold;
                  r_hold_valid  <= 1'b0;
                  r_last_loaded <= r_hold_last;
                  r_byte_cnt    <= w_cnt_inc;
                  r_tape        <= ~r_hold[7];
                  r_state       <= ST_DATA;
                end else begin
                  r_shift <= 8'h00;
                  r_tape  <= 1'b1;
                  r_state <= ST_STALL;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tape_player.sv
// ============================================================================
//  tb_tape_player : directed + randomized check of tape_player against a
//                   half-cell stream model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_tape_player;

  localparam int HT  = 2;
  localparam int PB  = 2;
  localparam int HT2 = 3;
  localparam int PB2 = 1;

  logic        clk = 1'b0;
  logic        reset_n, ce, start, stop, s_valid, s_last;
  logic [7:0]  s_data;
  logic        s_ready, tape_out, busy;
  logic [15:0] byte_cnt;

  logic        ce2, start2;
  logic        s_ready2, tape2, busy2;
  logic [15:0] byte_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc;

  bit           exp_q[$];
  logic [7:0]   pay_q[$];

  always #5 clk = ~clk;

  tape_player #(.HALF_TICKS(HT), .PREAMBLE_BYTES(PB), .SYNC_BYTE(8'hE6)) u_dut (
    .clk_sys(clk), .reset_n(reset_n), .ce_tick(ce), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .tape_out(tape_out), .busy(busy), .byte_cnt(byte_cnt)
  );

  tape_player #(.HALF_TICKS(HT2), .PREAMBLE_BYTES(PB2), .SYNC_BYTE(8'hE6)) u_dut2 (
    .clk_sys(clk), .reset_n(reset_n), .ce_tick(ce2), .start(start2), .stop(1'b0),
    .s_data(8'h00), .s_valid(1'b0), .s_last(1'b0), .s_ready(s_ready2),
    .tape_out(tape2), .busy(busy2), .byte_cnt(byte_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Biphase: each bit MSB first becomes (~bit, bit).
  function automatic void push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(~b[i]);
      exp_q.push_back(b[i]);
    end
  endfunction

  function automatic void push_frame_head(input int n_leader);
    for (int i = 0; i < n_leader; i++) push_byte(8'h00);
    push_byte(8'hE6);
  endfunction

  task automatic present_next();
    if (pay_q.size() > 0) begin
      s_valid = 1'b1;
      s_data  = pay_q[0];
      s_last  = (pay_q.size() == 1);
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // Follows exp_q from a fresh half-cell: after the edge that consumes tick t,
  // the line carries half-cell floor(t/HT). Past the end of exp_q the run
  // either finishes (busy/tape low) or the caller handles what comes next.
  task automatic run_stream(input int ce_pct, input bit expect_end);
    int  ticks   = 0;
    int  h       = 0;
    int  cyc     = 0;
    bit  fire;
    bit  all_acc = 1'b0;
    while (1) begin
      fire = s_valid & s_ready;
      ce   = ($urandom_range(99) < ce_pct);
      step();
      if (ce) ticks++;
      if (fire) begin
        n_acc++;
        void'(pay_q.pop_front());
        if (pay_q.size() == 0) all_acc = 1'b1;
        present_next();
      end
      if (all_acc) chk("ready_after_last", s_ready, 0);
      h = ticks / HT;
      if (h < exp_q.size()) begin
        chk("stream_tape", tape_out, exp_q[h]);
        chk("stream_busy", busy, 1);
      end else begin
        if (expect_end) begin
          chk("end_busy", busy, 0);
          chk("end_tape", tape_out, 0);
        end
        break;
      end
      cyc++;
      if (cyc > 4000) begin
        chk("stream_timeout", h, exp_q.size());
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last_edge;
    int edges[$];
    logic prev;

    reset_n = 1'b0; ce = 1'b0; start = 1'b0; stop = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    ce2 = 1'b0; start2 = 1'b0; n_acc = 0;
    #12;
    chk("rst_tape", tape_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_cnt", byte_cnt, 0);
    reset_n = 1'b1;
    step(); step();
    chk("idle_busy", busy, 0);

    // stop wins over start
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("stop_prio_busy", busy, 0);

    // Leader + sync with nothing fed, then underrun, then 0xA5 as last byte
    exp_q.delete(); pay_q.delete();
    push_frame_head(PB);
    ce = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_tape", tape_out, 1);
    chk("start_ready", s_ready, 1);
    chk("start_cnt", byte_cnt, 0);
    run_stream(100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_tape", tape_out, 1);
      chk("stall_busy", busy, 1);
      step();
    end
    chk("stall_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    chk("stall_fill_ready", s_ready, 0);
    chk("stall_fill_tape", tape_out, 1);
    step();
    chk("stall_exit_tape", tape_out, 0);
    exp_q.delete();
    push_byte(8'hA5);
    run_stream(100, 1'b1);
    chk("a5_cnt", byte_cnt, 1);
    chk("a5_ready", s_ready, 0);

    // Back-to-back payloads: fixed 00/FF/3C first, then random
    for (int r = 0; r < 4; r++) begin
      exp_q.delete(); pay_q.delete();
      if (r == 0) begin
        pay_q.push_back(8'h00); pay_q.push_back(8'hFF); pay_q.push_back(8'h3C);
      end else begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
      end
      n = pay_q.size();
      push_frame_head(PB);
      foreach (pay_q[i]) push_byte(pay_q[i]);
      n_acc = 0;
      present_next();
      start = 1'b1;
      step();
      start = 1'b0;
      run_stream((r < 2) ? 100 : $urandom_range(40, 90), 1'b1);
      chk("b2b_accepts", n_acc, n);
      chk("b2b_cnt", byte_cnt, n);
      step();
      chk("b2b_idle_busy", busy, 0);
    end
    s_valid = 1'b0;

    // stop in SYNC, then restart with start held high while busy
    ce = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 70; i++) step();
    chk("sync_busy_pre", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_tape", tape_out, 0);
    chk("stop_ready", s_ready, 0);
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("restart_tape", tape_out, ((k / HT) % 2 == 0) ? 1 : 0);
    end
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Async reset in the middle of DATA
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 98; i++) step();
    chk("data_cnt_pre", byte_cnt, 1);
    chk("data_ready_pre", s_ready, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_tape", tape_out, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", s_ready, 0);
    chk("async_cnt", byte_cnt, 0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_busy", busy, 0);
    end

    // Timebase: HT2 ticks per half with ce every 4th clock
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("tb2_start_tape", tape2, 1);
    prev = tape2;
    last_edge = 0;
    for (int c = 1; c < 400 && edges.size() < 4; c++) begin
      ce2 = ((c % 4) == 0);
      step();
      if (tape2 !== prev) edges.push_back(c);
      prev = tape2;
    end
    ce2 = 1'b0;
    chk("tb2_edges", edges.size(), 4);
    for (int i = 1; i < edges.size(); i++) begin
      last_edge = edges[i] - edges[i-1];
      chk("tb2_half_len", last_edge, 4 * HT2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
